// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered, handshaked RV32I immediate generator.
// Decodes the I/S/B/U/J immediate from the opcode, sign-extends it to XLEN,
// computes pc+imm and carries instr/pc downstream through a valid/ready stage.
// SKID=1 gives a 2-entry skid (registered in_ready); SKID=0 a single register.
// Optional feature macro: IMM_ILLEGAL_EN adds the out_illegal port.
module imm_gen_pipe #(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
`ifdef IMM_ILLEGAL_EN
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
`else
  output logic [XLEN-1:0] out_target
`endif
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [2:0]      fmt;
`ifdef IMM_ILLEGAL_EN
    logic            illegal;
`endif
  } entry_t;

  logic [6:0]      opcode;
  logic [31:0]     dec_imm32;
  logic [2:0]      dec_fmt;
  logic [XLEN-1:0] dec_imm;
  entry_t          in_entry;

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;

  logic   accept;
  logic   main_leave;

  assign opcode = in_instr[6:0];

  // Immediate format decode and 32-bit immediate assembly
  always_comb begin
    dec_imm32 = '0;
    dec_fmt   = FMT_NONE;
    case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        dec_fmt   = FMT_I;
        dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0100011: begin
        dec_fmt   = FMT_S;
        dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec_fmt   = FMT_B;
        dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt   = FMT_U;
        dec_imm32 = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt   = FMT_J;
        dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
      end
      default: begin
        dec_fmt   = FMT_NONE;
        dec_imm32 = '0;
      end
    endcase
  end

  // Sign-extend from bit 31 up to XLEN (no-op for XLEN=32)
  assign dec_imm = XLEN'($signed(dec_imm32));

`ifdef IMM_ILLEGAL_EN
  logic dec_illegal;

  // Illegal flag: non-32-bit encoding, or an opcode that is neither an
  // immediate format nor one of the immediate-free RV32I ops (OP, MISC-MEM)
  always_comb begin
    dec_illegal = 1'b0;
    if (opcode[1:0] != 2'b11) begin
      dec_illegal = 1'b1;
    end else if (dec_fmt == FMT_NONE &&
                 opcode != 7'b0110011 && opcode != 7'b0001111) begin
      dec_illegal = 1'b1;
    end
  end
`endif

  // Pack the decoded input into an entry, with the wrapping pc+imm add
  always_comb begin
    in_entry        = '0;
    in_entry.instr  = in_instr;
    in_entry.pc     = in_pc;
    in_entry.imm    = dec_imm;
    in_entry.target = in_pc + dec_imm;
    in_entry.fmt    = dec_fmt;
`ifdef IMM_ILLEGAL_EN
    in_entry.illegal = dec_illegal;
`endif
  end

  // SKID=1: ready only depends on a flop; SKID=0: ready looks through to out_ready
  assign in_ready   = (SKID != 0) ? ~skid_valid_q : (out_ready | ~main_valid_q);
  assign accept     = in_valid & in_ready & ~flush;
  assign main_leave = main_valid_q & out_ready;

  // Entry occupancy: flush dominates, then skid-to-main handoff, then loads
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_leave && skid_valid_q) begin
      // in_ready is low while the skid is full, so no accept can collide here
      main_d       = skid_q;
      skid_valid_d = 1'b0;
    end else if (main_leave || !main_valid_q) begin
      main_valid_d = accept;
      if (accept) begin
        main_d = in_entry;
      end
    end else if (accept && SKID != 0) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid  = main_valid_q;
  assign out_instr  = main_q.instr;
  assign out_pc     = main_q.pc;
  assign out_imm    = main_q.imm;
  assign out_fmt    = main_q.fmt;
  assign out_target = main_q.target;
`ifdef IMM_ILLEGAL_EN
  assign out_illegal = main_q.illegal;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench for imm_gen_pipe (XLEN=32, SKID=1).
// The driver pushes hand-computed expectations on accept; a monitor pops and
// compares on every output handshake. Directed checks cover reset, flush and
// backpressure.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic [31:0] out_target;
`ifdef IMM_ILLEGAL_EN
  logic        out_illegal;
`endif

  imm_gen_pipe #(.XLEN(32), .SKID(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .out_imm    (out_imm),
    .out_fmt    (out_fmt),
`ifdef IMM_ILLEGAL_EN
    .out_target (out_target),
    .out_illegal(out_illegal)
`else
    .out_target (out_target)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic [31:0] target;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end else begin
      $display("check %s: 0x%08h ok", name, act);
    end
  endtask

  // Monitor: every output handshake must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out: got instr=0x%08h with no pending item", out_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_instr !== e.instr || out_pc !== e.pc || out_imm !== e.imm ||
            out_fmt !== e.fmt || out_target !== e.target) begin
          n_err++;
          $display("FAIL out_txn: got instr=%08h pc=%08h imm=%08h fmt=%0d tgt=%08h expected instr=%08h pc=%08h imm=%08h fmt=%0d tgt=%08h",
                   out_instr, out_pc, out_imm, out_fmt, out_target,
                   e.instr, e.pc, e.imm, e.fmt, e.target);
        end else begin
          $display("out instr=%08h pc=%08h imm=%08h fmt=%0d tgt=%08h ok",
                   out_instr, out_pc, out_imm, out_fmt, out_target);
        end
      end
    end
  end

  // Offer one instruction; push its expectation when the handshake is seen
  task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] imm, input logic [2:0] fmt,
                      input logic [31:0] target);
    exp_t e;
    bit   done;
    e.instr = instr; e.pc = pc; e.imm = imm; e.fmt = fmt; e.target = target;
    in_instr = instr;
    in_pc    = pc;
    in_valid = 1'b1;
    done     = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: instr 0x%08h never accepted", instr);
    end
  endtask

  // Wait until the scoreboard drains, bounded
  task automatic drain();
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    check("drained_pending", exp_q.size(), 0);
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_imm", out_imm, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Formats and sign extension, downstream always ready
    send(32'hFFF00093, 32'h0000_0000, 32'hFFFF_FFFF, 3'd1, 32'hFFFF_FFFF); // addi -1
    send(32'hFE000EE3, 32'h0000_0100, 32'hFFFF_FFFC, 3'd3, 32'h0000_00FC); // beq -4
    send(32'h12345037, 32'h0000_0200, 32'h1234_5000, 3'd4, 32'h1234_5200); // lui
    send(32'h008000EF, 32'h0000_0040, 32'h0000_0008, 3'd5, 32'h0000_0048); // jal +8
    send(32'hFE112E23, 32'h0000_0010, 32'hFFFF_FFFC, 3'd2, 32'h0000_000C); // sw -4
    send(32'h00500093, 32'h0000_0008, 32'h0000_0005, 3'd1, 32'h0000_000D); // addi 5
    send(32'h00001017, 32'h0000_0004, 32'h0000_1000, 3'd4, 32'h0000_1004); // auipc
    send(32'h7FF000E7, 32'h0000_1000, 32'h0000_07FF, 3'd1, 32'h0000_17FF); // jalr max+
    send(32'hFFC02083, 32'h0000_0000, 32'hFFFF_FFFC, 3'd1, 32'hFFFF_FFFC); // lw, wraps
    send(32'h002081B3, 32'h0000_0020, 32'h0000_0000, 3'd0, 32'h0000_0020); // R-type
    send(32'h00000000, 32'h0000_0024, 32'h0000_0000, 3'd0, 32'h0000_0024); // all zero
    drain();

    // Backpressure: two fill MAIN/SKID, third waits until skid frees
    out_ready = 1'b0;
    send(32'h00100093, 32'h0000_0300, 32'h0000_0001, 3'd1, 32'h0000_0301);
    send(32'h00200093, 32'h0000_0304, 32'h0000_0002, 3'd1, 32'h0000_0306);
    fork
      send(32'h00300093, 32'h0000_0308, 32'h0000_0003, 3'd1, 32'h0000_030B);
      begin
        @(negedge clk);
        check("full_in_ready", in_ready, 0);
        check("full_hold_instr", out_instr, 32'h00100093);
        @(negedge clk);
        check("full_stable_instr", out_instr, 32'h00100093);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Flush while FULL with a valid input: everything discarded
    out_ready = 1'b0;
    send(32'h00400093, 32'h0000_0400, 32'h0000_0004, 3'd1, 32'h0000_0404);
    send(32'h00500093, 32'h0000_0404, 32'h0000_0005, 3'd1, 32'h0000_0409);
    in_instr = 32'h00600093;
    in_pc    = 32'h0000_0408;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("flush_still_empty", out_valid, 0);

    // Asynchronous reset in the middle of backpressure
    out_ready = 1'b0;
    send(32'h12345037, 32'h0000_0500, 32'h1234_5000, 3'd4, 32'h1234_5500);
    send(32'h008000EF, 32'h0000_0504, 32'h0000_0008, 3'd5, 32'h0000_050C);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_out_instr", out_instr, 0);
    check("arst_out_pc", out_pc, 0);
    check("arst_out_target", out_target, 0);
    check("arst_out_fmt", {29'd0, out_fmt}, 0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    send(32'hFE000EE3, 32'h0000_0100, 32'hFFFF_FFFC, 3'd3, 32'h0000_00FC);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
